// File: rtl/xt_hb_domain_mux.sv
// HB slave-domain decoder/mux: parametrised address windows, per-slave read latency FSM.
// Optional decode-error capture is enabled by defining XT_HB_DOMAIN_ERR_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package XT_BUS;
  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] raddr;
    logic [`ADDR_WIDTH-1:0] waddr;
    logic [31:0]            wdata;
  } hb_slave_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;
endpackage

module xt_hb_domain_mux
  import XT_BUS::*;
#(
  parameter int unsigned SLAVE_NUM              = 4,
  parameter int unsigned SLAVE_BASE [SLAVE_NUM] = '{0, 4, 12, 28},
  parameter int unsigned SLAVE_SIZE [SLAVE_NUM] = '{4, 8, 16, 4},
  parameter int unsigned SLAVE_RLAT [SLAVE_NUM] = '{1, 1, 1, 1}
) (
  input  logic                          hb_clk,
  input  logic                          hb_rst_n,
  input  hb_slave_t                     xt_hb,
  input  sel_t                          sel,
  input  logic [SLAVE_NUM-1:0][31:0]    hb_data_in,
  input  logic                          err_clr,
  output logic                          read_finish,
  output logic                          write_finish,
  output logic [31:0]                   rdata,
  output sel_t [SLAVE_NUM-1:0]          hb_sel,
  output logic                          access_err,
  output logic [`ADDR_WIDTH-1:0]        err_addr,
  output logic                          err_is_write
);

  localparam int unsigned IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_read_finish;
  logic [31:0]      r_rdata;

  logic             w_rhit;
  logic [IDX_W-1:0] w_ridx;
  logic [3:0]       w_rlat;
  logic             w_whit;
  logic [IDX_W-1:0] w_widx;
  logic             w_rd_accept;
  logic             w_unused;

  function automatic logic in_win(input logic [`ADDR_WIDTH-1:0] addr, input int unsigned i);
    logic [63:0] a;
    logic [63:0] lo;
    logic [63:0] hi;
    a  = 64'(addr);
    lo = 64'(SLAVE_BASE[i]);
    hi = lo + 64'(SLAVE_SIZE[i]);
    return (a >= lo) && (a < hi);
  endfunction

  // First match in ascending index order gives the lowest index priority on overlaps.
  always_comb begin
    w_rhit = 1'b0;
    w_ridx = '0;
    w_rlat = '0;
    w_whit = 1'b0;
    w_widx = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (!w_rhit && in_win(xt_hb.raddr, i)) begin
        w_rhit = 1'b1;
        w_ridx = IDX_W'(i);
        w_rlat = 4'(SLAVE_RLAT[i]);
      end
      if (!w_whit && in_win(xt_hb.waddr, i)) begin
        w_whit = 1'b1;
        w_widx = IDX_W'(i);
      end
    end
  end

  assign w_rd_accept = (r_state == S_IDLE) && sel.ren;

  always_comb begin
    hb_sel = '0;
    if (sel.wen && w_whit) hb_sel[w_widx].wen = 1'b1;
    if (w_rd_accept && w_rhit) hb_sel[w_ridx].ren = 1'b1;
  end

  assign write_finish = 1'b1;
  assign read_finish  = r_read_finish;
  assign rdata        = r_rdata;

  // read_finish is registered, so capture happens one cycle before the finish cycle:
  // RLAT=1 captures straight from IDLE, longer latencies capture in WAIT when cnt reaches 1.
  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_read_finish <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_read_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sel.ren) begin
            r_idx <= w_ridx;
            if (!w_rhit) begin
              r_rdata       <= '0;
              r_read_finish <= 1'b1;
              r_state       <= S_FINISH;
            end else if (w_rlat <= 4'd1) begin
              r_rdata       <= hb_data_in[w_ridx];
              r_read_finish <= 1'b1;
              r_state       <= S_FINISH;
            end else begin
              r_cnt   <= 3'(w_rlat - 4'd1);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt <= 3'd1) begin
            r_rdata       <= hb_data_in[r_idx];
            r_read_finish <= 1'b1;
            r_state       <= S_FINISH;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

`ifdef XT_HB_DOMAIN_ERR_EN
  logic                   r_access_err;
  logic [`ADDR_WIDTH-1:0] r_err_addr;
  logic                   r_err_is_write;
  logic                   w_rerr;
  logic                   w_werr;

  assign w_rerr = w_rd_accept && !w_rhit;
  assign w_werr = sel.wen && !w_whit;

  // A new error in the clear cycle wins and reloads the capture registers.
  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      r_access_err   <= 1'b0;
      r_err_addr     <= '0;
      r_err_is_write <= 1'b0;
    end else if (w_rerr || w_werr) begin
      r_access_err <= 1'b1;
      if (!r_access_err || err_clr) begin
        r_err_addr     <= w_rerr ? xt_hb.raddr : xt_hb.waddr;
        r_err_is_write <= !w_rerr;
      end
    end else if (err_clr) begin
      r_access_err   <= 1'b0;
      r_err_addr     <= '0;
      r_err_is_write <= 1'b0;
    end
  end

  assign access_err   = r_access_err;
  assign err_addr     = r_err_addr;
  assign err_is_write = r_err_is_write;
  assign w_unused     = ^xt_hb.wdata;
`else
  assign access_err   = 1'b0;
  assign err_addr     = '0;
  assign err_is_write = 1'b0;
  assign w_unused     = ^{xt_hb.wdata, err_clr};
`endif

endmodule

// File: tb/tb_xt_hb_domain_mux.sv
// Scoreboard bench for xt_hb_domain_mux: reads push expected data/finish cycle, a monitor pops on read_finish.
module tb_xt_hb_domain_mux;
  import XT_BUS::*;

`ifdef XT_HB_DOMAIN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                 hb_clk;
  logic                 hb_rst_n;
  hb_slave_t            xt_hb;
  sel_t                 sel;
  logic [3:0][31:0]     hb_data_in;
  logic                 err_clr;
  logic                 read_finish;
  logic                 write_finish;
  logic [31:0]          rdata;
  sel_t [3:0]           hb_sel;
  logic                 access_err;
  logic [`ADDR_WIDTH-1:0] err_addr;
  logic                 err_is_write;

  xt_hb_domain_mux #(
    .SLAVE_NUM (4),
    .SLAVE_RLAT('{1, 1, 4, 1})
  ) dut (
    .hb_clk      (hb_clk),
    .hb_rst_n    (hb_rst_n),
    .xt_hb       (xt_hb),
    .sel         (sel),
    .hb_data_in  (hb_data_in),
    .err_clr     (err_clr),
    .read_finish (read_finish),
    .write_finish(write_finish),
    .rdata       (rdata),
    .hb_sel      (hb_sel),
    .access_err  (access_err),
    .err_addr    (err_addr),
    .err_is_write(err_is_write)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  initial hb_clk = 1'b0;
  always #5 hb_clk = ~hb_clk;

  initial cyc = 0;
  always @(posedge hb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic check_err(input string name, input logic e, input logic [63:0] a, input logic w);
    check({name, "_access_err"},   64'(access_err),   ERR_EN ? 64'(e) : 64'd0);
    check({name, "_err_addr"},     64'(err_addr),     ERR_EN ? a : 64'd0);
    check({name, "_err_is_write"}, 64'(err_is_write), ERR_EN ? 64'(w) : 64'd0);
  endtask

  // Issue a read in T0, check T0 hb_sel, hold ren until the finish cycle, then release.
  task automatic do_read(input string name, input logic [31:0] addr, input logic [7:0] exp_sel,
                         input logic [31:0] exp_data, input int unsigned lat);
    xt_hb.raddr = addr;
    sel.ren     = 1'b1;
    q.push_back('{exp_data, cyc + lat});
    #1 check({name, "_hb_sel_T0"}, 64'(hb_sel), 64'(exp_sel));
    repeat (lat) tick();
    sel.ren = 1'b0;
    tick();
  endtask

  always @(negedge hb_clk) begin
    if (read_finish) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_read_finish: got read_finish=1 at cycle %0d, required 0 (no read pending)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("rd_data", 64'(rdata), 64'(mon_e.data));
        check("rd_finish_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end else if (q.size() > 0 && cyc > q[0].cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL rd_timeout: got no read_finish by cycle %0d, required at cycle %0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    hb_rst_n   = 1'b0;
    xt_hb      = '0;
    sel        = '0;
    hb_data_in = '0;
    err_clr    = 1'b0;
    repeat (3) tick();

    check("rst_read_finish", 64'(read_finish), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_hb_sel", 64'(hb_sel), 64'd0);
    check("rst_write_finish", 64'(write_finish), 64'd1);
    check_err("rst", 1'b0, 64'd0, 1'b0);
    hb_rst_n = 1'b1;
    tick();

    // Single-cycle read of slave 0; ren still high in FINISH must not re-select.
    hb_data_in[0] = 32'hA5A5_0001;
    xt_hb.raddr   = 32'd0;
    sel.ren       = 1'b1;
    q.push_back('{32'hA5A5_0001, cyc + 1});
    #1 check("t1_hb_sel_T0", 64'(hb_sel), 64'h02);
    tick();
    check("t1_hb_sel_T1", 64'(hb_sel), 64'h00);
    sel.ren = 1'b0;
    tick();

    // Slave 2 with latency 4; data changes in T3; concurrent write to slave 3 in T1.
    hb_data_in[2] = 32'hDEAD_0000;
    xt_hb.raddr   = 32'd16;
    sel.ren       = 1'b1;
    q.push_back('{32'h0000_1234, cyc + 4});
    #1 check("t2_hb_sel_T0", 64'(hb_sel), 64'h20);
    tick();
    xt_hb.waddr = 32'd29;
    sel.wen     = 1'b1;
    #1 check("t4_hb_sel_wen", 64'(hb_sel), 64'h40);
    check("t4_write_finish", 64'(write_finish), 64'd1);
    tick();
    sel.wen = 1'b0;
    #1 check("t2_no_reren_T2", 64'(hb_sel), 64'h00);
    tick();
    hb_data_in[2] = 32'h0000_1234;
    #1 check("t2_no_reren_T3", 64'(hb_sel), 64'h00);
    tick();
    sel.ren = 1'b0;
    tick();

    // Window boundaries.
    hb_data_in[1] = 32'h1111_0011;
    do_read("b_rd11", 32'd11, 8'h08, 32'h1111_0011, 1);
    hb_data_in[2] = 32'h2222_0012;
    do_read("b_rd12", 32'd12, 8'h20, 32'h2222_0012, 4);
    sel.wen = 1'b1;
    xt_hb.waddr = 32'd3;
    #1 check("b_wr3", 64'(hb_sel), 64'h01);
    xt_hb.waddr = 32'd4;
    #1 check("b_wr4", 64'(hb_sel), 64'h04);
    xt_hb.waddr = 32'd31;
    #1 check("b_wr31", 64'(hb_sel), 64'h40);
    xt_hb.waddr = 32'd0;
    sel.wen = 1'b0;
    tick();
    check_err("b_noerr", 1'b0, 64'd0, 1'b0);

    // Unmapped read.
    do_read("t3_rd40", 32'd40, 8'h00, 32'h0, 1);
    check_err("t3", 1'b1, 64'd40, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_err("t3_clr", 1'b0, 64'd0, 1'b0);

    // First error preserved, then clear with simultaneous new error.
    xt_hb.waddr = 32'd50;
    sel.wen     = 1'b1;
    #1 check("t5_wr50_hb_sel", 64'(hb_sel), 64'h00);
    tick();
    sel.wen = 1'b0;
    check_err("t5_first", 1'b1, 64'd50, 1'b1);
    do_read("t5_rd60", 32'd60, 8'h00, 32'h0, 1);
    check_err("t5_held", 1'b1, 64'd50, 1'b1);
    err_clr     = 1'b1;
    xt_hb.waddr = 32'd70;
    sel.wen     = 1'b1;
    tick();
    err_clr = 1'b0;
    sel.wen = 1'b0;
    check_err("t5_reload", 1'b1, 64'd70, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Unmapped read and write together: read recorded.
    xt_hb.raddr = 32'd80;
    xt_hb.waddr = 32'd90;
    sel.ren     = 1'b1;
    sel.wen     = 1'b1;
    q.push_back('{32'h0, cyc + 1});
    tick();
    sel.ren = 1'b0;
    sel.wen = 1'b0;
    check_err("t5_both", 1'b1, 64'd80, 1'b0);
    tick();

    // Reset during WAIT.
    hb_data_in[1] = 32'h5555_AAAA;
    do_read("t6_pre", 32'd4, 8'h08, 32'h5555_AAAA, 1);
    xt_hb.raddr = 32'd16;
    sel.ren     = 1'b1;
    tick();
    tick();
    hb_rst_n = 1'b0;
    #1;
    check("t6_rst_read_finish", 64'(read_finish), 64'd0);
    check("t6_rst_rdata", 64'(rdata), 64'd0);
    check_err("t6_rst", 1'b0, 64'd0, 1'b0);
    sel.ren = 1'b0;
    tick();
    tick();
    hb_rst_n = 1'b1;
    tick();
    hb_data_in[0] = 32'h600D_0000;
    do_read("t6_post", 32'd0, 8'h02, 32'h600D_0000, 1);

    repeat (8) tick();
    check("pending_reads", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
